// File: rtl/alu_md_pkg.sv
// Shared definitions for the alu_md slice: opcode values, FSM state encoding and default width.
package alu_md_pkg;

  localparam int unsigned DefWidth = 32;

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpOr    = 4'd2;
  localparam logic [3:0] OpAnd   = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpSlt   = 4'd5;
  localparam logic [3:0] OpSltu  = 4'd6;
  localparam logic [3:0] OpRsvd  = 4'd7;
  localparam logic [3:0] OpMultu = 4'd8;
  localparam logic [3:0] OpMult  = 4'd9;
  localparam logic [3:0] OpDivu  = 4'd10;
  localparam logic [3:0] OpDiv   = 4'd11;
  localparam logic [3:0] OpMfhi  = 4'd12;
  localparam logic [3:0] OpMflo  = 4'd13;
  localparam logic [3:0] OpMthi  = 4'd14;
  localparam logic [3:0] OpMtlo  = 4'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

  // Opcodes 8..11 start the iterative engine.
  function automatic logic is_md_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_md_engine.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide, one bit per step,
// with operand magnitude capture on load and combinational sign fix-up of the raw result.
module md_engine #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, dvd_q, dvd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Signed operands are reduced to magnitudes; the signs are reapplied after the last step.
  assign a_neg = sgn_i & a_i[WIDTH-1];
  assign b_neg = sgn_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_rem = {hi_q, lo_q[WIDTH-1]};
  assign div_ge  = div_rem >= {1'b0, opnd_q};
  // When div_ge holds the true difference is below the divisor, so WIDTH bits are exact.
  assign div_sub = div_rem[WIDTH-1:0] - opnd_q;

  assign last_o = (cnt_q == CntW'(1));

  // Next-state for the iteration registers.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    dvd_d  = dvd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (load_i) begin
      hi_d   = '0;
      lo_d   = a_mag;
      opnd_d = b_mag;
      dvd_d  = a_i;
      cnt_d  = CntW'(WIDTH);
      div_d  = div_i;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      dz_d   = (b_i == '0);
    end else if (step_i) begin
      cnt_d = cnt_q - CntW'(1);
      if (div_q) begin
        hi_d = div_ge ? div_sub : div_rem[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], div_ge};
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Engine state registers, cleared by reset to abort any operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      dvd_q  <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      dvd_q  <= dvd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;

  // Sign fix-up of the raw result; divide by zero bypasses the iteration result.
  always_comb begin
    hi_o = prod_fix[2*WIDTH-1:WIDTH];
    lo_o = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (dz_q) begin
        lo_o = '1;
        hi_o = dvd_q;
      end else begin
        lo_o = neg_q ? -lo_q : lo_q;
        hi_o = rneg_q ? -hi_q : hi_q;
      end
    end
  end

endmodule

// File: rtl/alu_md.sv
// ALU with HI/LO multiply/divide unit. Combinational ALU result plus an IDLE/RUN/FIX sequencer
// driving md_engine. Define ALU_MD_SIGNED_EN to make MULT/DIV signed; otherwise they alias
// MULTU/DIVU with identical latency.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned ADDR_HI = 11,
  parameter int unsigned ADDR_LO = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     start,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic                     ovf,
  output logic [ADDR_HI-ADDR_LO:0] mem_addr,
  output logic                     busy,
  output logic                     done
);

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] sum, diff;
  logic             eng_load, eng_step, eng_last, eng_div, eng_sgn;
  logic [WIDTH-1:0] eng_hi, eng_lo;

  assign sum  = a + b;
  assign diff = a - b;

  // Combinational ALU result and overflow, independent of the engine state.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OpAdd: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpOr:   result = a | b;
      OpAnd:  result = a & b;
      OpXor:  result = a ^ b;
      OpSlt:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu: result = {{(WIDTH-1){1'b0}}, (a < b)};
      OpMfhi: result = hi_q;
      OpMflo: result = lo_q;
      default: result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign mem_addr = result[ADDR_HI:ADDR_LO];

  assign eng_load = (state_q == StIdle) && start && is_md_op(op);
  assign eng_step = (state_q == StRun);
  assign eng_div  = op[1];
`ifdef ALU_MD_SIGNED_EN
  assign eng_sgn  = op[0];
`else
  assign eng_sgn  = 1'b0;
`endif

  md_engine #(
    .WIDTH(WIDTH)
  ) u_md_engine (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (eng_load),
    .step_i (eng_step),
    .div_i  (eng_div),
    .sgn_i  (eng_sgn),
    .a_i    (a),
    .b_i    (b),
    .last_o (eng_last),
    .hi_o   (eng_hi),
    .lo_o   (eng_lo)
  );

  // Sequencer with registered busy/done; HI/LO only change from IDLE moves or the FIX exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (is_md_op(op)) begin
              state_q <= StRun;
              busy    <= 1'b1;
            end else if (op == OpMthi) begin
              hi_q <= a;
            end else if (op == OpMtlo) begin
              lo_q <= a;
            end
          end
        end
        StRun: begin
          if (eng_last) state_q <= StFix;
        end
        StFix: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b1;
          hi_q    <= eng_hi;
          lo_q    <= eng_lo;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning datapath width in bits (legal 8..64, even).
REQ-002 The block SHALL have parameter ADDR_HI, default 11, meaning the top bit of the mem_addr slice.
REQ-003 The block SHALL have parameter ADDR_LO, default 2, meaning the bottom bit of the mem_addr slice.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-005 The block SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 The block SHALL have port op  input  4  meaning operation select.
REQ-007 The block SHALL have ports a and b  input  WIDTH  meaning operands.
REQ-008 The block SHALL have port start  input  1  meaning request strobe for multiply, divide, MTHI and MTLO.
REQ-009 The block SHALL have port result  output  WIDTH  meaning the combinational result.
REQ-010 The block SHALL have port zero  output  1  meaning result equals 0.
REQ-011 The block SHALL have port ovf  output  1  meaning signed overflow on ADD/SUB, else 0.
REQ-012 The block SHALL have port mem_addr  output  ADDR_HI-ADDR_LO+1  meaning result[ADDR_HI:ADDR_LO].
REQ-013 The block SHALL have port busy  output  1  meaning the multiply/divide engine is running.
REQ-014 The block SHALL have port done  output  1  meaning a one-cycle pulse when HI/LO have been updated by the engine.

Function
REQ-015 Opcodes SHALL be: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SLT, 6 SLTU, 7 reserved (result 0), 8 MULTU, 9 MULT, 10 DIVU, 11 DIV, 12 MFHI, 13 MFLO, 14 MTHI, 15 MTLO.
REQ-016 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf SHALL be set on two's-complement overflow.
REQ-017 SLT/SLTU SHALL return 1 or 0 (signed/unsigned compare); MFHI/MFLO SHALL return HI/LO; ops 8-11, 14 and 15 SHALL return 0.
REQ-018 result, zero, ovf and mem_addr SHALL be purely combinational and valid regardless of busy.
REQ-019 The FSM SHALL have states IDLE, RUN and FIX.
REQ-020 start with op 8-11 in IDLE SHALL latch the operands on that edge and move to RUN.
REQ-021 RUN SHALL last exactly WIDTH cycles: shift-add for multiply, restoring for divide, one bit per cycle.
REQ-022 After RUN the FSM SHALL spend one cycle in FIX for sign fix-up, then return to IDLE.
REQ-023 busy SHALL be high in RUN and FIX (WIDTH+1 cycles); HI/LO SHALL be written on the FIX->IDLE edge; done SHALL be high for the following cycle only.
REQ-024 Multiply SHALL produce {HI,LO} = the 2*WIDTH-bit product; divide SHALL produce LO = quotient and HI = remainder.
REQ-025 For signed divide, the remainder SHALL take the sign of the dividend.
REQ-026 Divide by zero SHALL give LO = all ones and HI = dividend, with the same latency.
REQ-027 Signed divide of the most-negative value by -1 SHALL give LO = most-negative value and HI = 0.
REQ-028 start while busy SHALL be ignored entirely, including MTHI/MTLO.
REQ-029 start with op 14 or 15 in IDLE SHALL write a into HI or LO respectively on that edge; done SHALL NOT pulse.
REQ-030 start with any other op SHALL be ignored.
REQ-031 A start accepted on the same edge that busy falls SHALL NOT be possible; the FSM SHALL be in IDLE for at least one cycle between operations.

Reset
REQ-032 rst_n low SHALL asynchronously force the FSM to IDLE and clear HI, LO, busy, done and all engine registers to 0, aborting any operation in progress.
REQ-033 After rst_n rises, the first start SHALL be accepted on the first clock edge.

Configuration
REQ-034 With ALU_MD_SIGNED_EN defined, MULT and DIV SHALL be signed per REQ-024 to REQ-027.
REQ-035 Without ALU_MD_SIGNED_EN, opcodes 9 and 11 SHALL behave exactly as 8 and 10, and the FIX state SHALL remain as an idle cycle so latency is unchanged.

Structure
REQ-036 Package alu_md_pkg SHALL hold the opcode constants, the FSM state encoding and the default WIDTH.
REQ-037 Sub-module md_engine SHALL hold the iterative multiply/divide datapath and the counter; alu_md SHALL hold the combinational ALU, HI/LO and the FSM.

Verification
REQ-038 ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf 1, zero 0; SUB 5-5 -> result 0, zero 1.
REQ-039 MULTU 7*6 -> busy for 33 cycles, done pulse, then MFLO = 42 and MFHI = 0.
REQ-040 MULT -3*5 (signed build) -> HI 0xFFFFFFFF, LO 0xFFFFFFF1; unsigned build -> HI 0x00000004, LO 0xFFFFFFF1.
REQ-041 DIV -7/2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF; DIVU 9/0 -> LO 0xFFFFFFFF, HI 9.
REQ-042 MTHI 0x1234 during busy -> HI unchanged; rst_n pulsed mid-RUN -> busy 0, HI = LO = 0, no done.
REQ-043 WIDTH=16, ADD 0x0ABC+0 -> mem_addr = 0x2AF; MULTU 0xFFFF*0xFFFF -> HI 0xFFFE, LO 0x0001 after 17 busy cycles.
